alu_op_decoder: RTL and testbench

Two-stage issue/writeback front end for the 32-bit ALU. It accepts RV32I ALU instructions (R-type, I-type ALU, LUI) with their register operands over a valid/ready handshake. It decodes each one into the ALU's 4-bit opcode and two operands, and drives them to the combinational ALU from a register stage. It then captures the ALU result and presents it to the register-file writeback port, with backpressure.

---
 rtl/alu_op_decoder_if.sv | 42 ++++
 rtl/alu_op_decoder.sv | 179 +++++++++++++++++
 tb/tb_alu_op_decoder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decoder_if
// Brief    : Issue, ALU-drive and writeback bundle for alu_op_decoder.
// Revision : 1.0
// ============================================================================
interface alu_op_decoder_if #(
  parameter int XLEN = 32
);
  logic            instr_valid_in;
  logic            instr_ready_o;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] rs1_data_in;
  logic [XLEN-1:0] rs2_data_in;
  logic [XLEN-1:0] op_1_o;
  logic [XLEN-1:0] op_2_o;
  logic [3:0]      opcode_o;
  logic [XLEN-1:0] alu_result_in;
  logic            wb_valid_o;
  logic            wb_ready_in;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic            wb_we_o;
  logic            wb_illegal_o;

  // Decoder side
  modport slave (
    input  instr_valid_in, instr_in, rs1_data_in, rs2_data_in,
           alu_result_in, wb_ready_in,
    output instr_ready_o, op_1_o, op_2_o, opcode_o,
           wb_valid_o, wb_rd_o, wb_data_o, wb_we_o, wb_illegal_o
  );

  // Issue logic, ALU and register file side
  modport master (
    output instr_valid_in, instr_in, rs1_data_in, rs2_data_in,
           alu_result_in, wb_ready_in,
    input  instr_ready_o, op_1_o, op_2_o, opcode_o,
           wb_valid_o, wb_rd_o, wb_data_o, wb_we_o, wb_illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decoder
// Brief    : Two-stage RV32I ALU issue/writeback front end. Optional build
//            macro ALU_DEC_SHAMT_MASK_EN masks R-type shift amounts to 5 bits.
// Revision : 1.0
// ============================================================================
module alu_op_decoder #(
  parameter int XLEN = 32
) (
  input wire             clk_in,
  input wire             rst_n_in,
  alu_op_decoder_if.slave bus
);

  localparam logic [6:0] c_MAJ_OP    = 7'b0110011;
  localparam logic [6:0] c_MAJ_OPIMM = 7'b0010011;
  localparam logic [6:0] c_MAJ_LUI   = 7'b0110111;
  localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
  localparam logic [6:0] c_F7_ALT    = 7'b0100000;
  localparam logic [2:0] c_F3_SLL    = 3'b001;
  localparam logic [2:0] c_F3_SR     = 3'b101;
  localparam logic [2:0] c_F3_ADD    = 3'b000;

  // ---------------- instruction fields ----------------
  logic [6:0]      w_major;
  logic [4:0]      w_rd;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;

  assign w_major = bus.instr_in[6:0];
  assign w_rd    = bus.instr_in[11:7];
  assign w_f3    = bus.instr_in[14:12];
  assign w_f7    = bus.instr_in[31:25];
  assign w_imm_i = {{(XLEN-12){bus.instr_in[31]}}, bus.instr_in[31:20]};
  assign w_imm_u = {bus.instr_in[31:12], 12'b0};
  assign w_shamt = {{(XLEN-5){1'b0}}, bus.instr_in[24:20]};

  // ---------------- decode ----------------
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [3:0]      w_opc;
  logic            w_illegal;
  logic            w_we;

  always_comb begin
    w_op1     = '0;
    w_op2     = '0;
    w_opc     = 4'b0000;
    w_illegal = 1'b1;
    case (w_major)
      c_MAJ_OP: begin
        w_op1 = bus.rs1_data_in;
        w_op2 = bus.rs2_data_in;
        w_opc = {w_f7[5], w_f3};
        if (w_f7 == c_F7_ZERO) begin
          w_illegal = 1'b0;
        end else if (w_f7 == c_F7_ALT && (w_f3 == c_F3_ADD || w_f3 == c_F3_SR)) begin
          w_illegal = 1'b0;
        end
`ifdef ALU_DEC_SHAMT_MASK_EN
        if (w_f3 == c_F3_SLL || w_f3 == c_F3_SR) begin
          w_op2 = {{(XLEN-5){1'b0}}, bus.rs2_data_in[4:0]};
        end
`endif
      end
      c_MAJ_OPIMM: begin
        w_op1     = bus.rs1_data_in;
        w_op2     = w_imm_i;
        w_opc     = {1'b0, w_f3};
        w_illegal = 1'b0;
        case (w_f3)
          c_F3_SLL: begin
            w_op2     = w_shamt;
            w_illegal = (w_f7 != c_F7_ZERO);
          end
          c_F3_SR: begin
            w_op2 = w_shamt;
            if (w_f7 == c_F7_ALT) begin
              w_opc = 4'b1101;
            end else if (w_f7 != c_F7_ZERO) begin
              w_illegal = 1'b1;
            end
          end
          default: ;
        endcase
      end
      c_MAJ_LUI: begin
        w_op2     = w_imm_u;
        w_illegal = 1'b0;
      end
      default: ;
    endcase
    // Illegal encodings present a harmless add of zeros to the ALU
    if (w_illegal) begin
      w_op1 = '0;
      w_op2 = '0;
      w_opc = 4'b0000;
    end
  end

  assign w_we = !w_illegal && (w_rd != 5'd0);

  // ---------------- pipeline control ----------------
  logic            r_s1_valid;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [3:0]      r_opc;
  logic [4:0]      r_s1_rd;
  logic            r_s1_we;
  logic            r_s1_illegal;

  logic            r_s2_valid;
  logic [XLEN-1:0] r_wb_data;
  logic [4:0]      r_wb_rd;
  logic            r_wb_we;
  logic            r_wb_illegal;

  logic w_s2_advance;
  logic w_s1_advance;

  assign w_s2_advance = !r_s2_valid || bus.wb_ready_in;
  assign w_s1_advance = !r_s1_valid || w_s2_advance;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_valid   <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_opc        <= 4'b0000;
      r_s1_rd      <= 5'd0;
      r_s1_we      <= 1'b0;
      r_s1_illegal <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rd      <= 5'd0;
      r_wb_we      <= 1'b0;
      r_wb_illegal <= 1'b0;
    end else begin
      if (w_s2_advance) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_wb_data    <= bus.alu_result_in;
          r_wb_rd      <= r_s1_rd;
          r_wb_we      <= r_s1_we;
          r_wb_illegal <= r_s1_illegal;
        end
      end
      // S1 refills on the same edge S2 drains, keeping full throughput
      if (w_s1_advance) begin
        r_s1_valid <= bus.instr_valid_in;
        if (bus.instr_valid_in) begin
          r_op1        <= w_op1;
          r_op2        <= w_op2;
          r_opc        <= w_opc;
          r_s1_rd      <= w_rd;
          r_s1_we      <= w_we;
          r_s1_illegal <= w_illegal;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.instr_ready_o = w_s1_advance;
  assign bus.op_1_o        = r_op1;
  assign bus.op_2_o        = r_op2;
  assign bus.opcode_o      = r_opc;
  assign bus.wb_valid_o    = r_s2_valid;
  assign bus.wb_rd_o       = r_wb_rd;
  assign bus.wb_data_o     = r_wb_data;
  assign bus.wb_we_o       = r_wb_we;
  assign bus.wb_illegal_o  = r_wb_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_decoder
// Brief    : Directed scoreboard bench for alu_op_decoder with a behavioural ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_op_decoder;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        ill;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    n_cmp = 0;
  int    n_err = 0;
  exp_t  sb_q[$];
  exp_t  e_pop;
  logic        stall_prev = 1'b0;
  logic [31:0] snap_data;
  logic [31:0] snap_ctl;
  logic [31:0] alu_y;

  alu_op_decoder_if #(.XLEN(32)) bus ();

  alu_op_decoder #(.XLEN(32)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; shifts use the full operand-2 value
  always_comb begin
    case (bus.opcode_o)
      4'b0000: alu_y = bus.op_1_o + bus.op_2_o;
      4'b0001: alu_y = bus.op_1_o << bus.op_2_o;
      4'b0010: alu_y = {31'b0, $signed(bus.op_1_o) < $signed(bus.op_2_o)};
      4'b0011: alu_y = {31'b0, bus.op_1_o < bus.op_2_o};
      4'b0100: alu_y = bus.op_1_o ^ bus.op_2_o;
      4'b0101: alu_y = bus.op_1_o >> bus.op_2_o;
      4'b0110: alu_y = bus.op_1_o | bus.op_2_o;
      4'b0111: alu_y = bus.op_1_o & bus.op_2_o;
      4'b1000: alu_y = bus.op_1_o - bus.op_2_o;
      4'b1101: alu_y = $signed(bus.op_1_o) >>> bus.op_2_o;
      default: alu_y = 32'h0;
    endcase
  end
  assign bus.alu_result_in = alu_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: retire on handshake, and check hold while stalled
  always begin
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && bus.wb_valid_o === 1'b1) begin
      if (bus.wb_ready_in) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 32'(sb_q.size()), 32'd1);
        end else begin
          e_pop = sb_q.pop_front();
          chk("wb_rd",      {27'b0, bus.wb_rd_o},     {27'b0, e_pop.rd});
          chk("wb_data",    bus.wb_data_o,            e_pop.data);
          chk("wb_we",      {31'b0, bus.wb_we_o},      {31'b0, e_pop.we});
          chk("wb_illegal", {31'b0, bus.wb_illegal_o}, {31'b0, e_pop.ill});
        end
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("wb_hold_data", bus.wb_data_o, snap_data);
          chk("wb_hold_ctl", {25'b0, bus.wb_rd_o, bus.wb_we_o, bus.wb_illegal_o}, snap_ctl);
        end
        stall_prev = 1'b1;
        snap_data  = bus.wb_data_o;
        snap_ctl   = {25'b0, bus.wb_rd_o, bus.wb_we_o, bus.wb_illegal_o};
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] rd, input logic [31:0] data,
                       input logic we, input logic ill);
    exp_t e;
    bus.instr_valid_in = 1'b1;
    bus.instr_in       = ins;
    bus.rs1_data_in    = r1;
    bus.rs2_data_in    = r2;
    e.rd = rd; e.data = data; e.we = we; e.ill = ill;
    sb_q.push_back(e);
  endtask

  task automatic wait_accept();
    int guard = 0;
    #1;
    while (bus.instr_ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid_in = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [31:0] ins,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] rd, input logic [31:0] data,
                          input logic we, input logic ill,
                          input logic [3:0] opc, input logic [31:0] op1, input logic [31:0] op2);
    drive(ins, r1, r2, rd, data, we, ill);
    wait_accept();
    chk({tag, ".opcode"}, {28'b0, bus.opcode_o}, {28'b0, opc});
    chk({tag, ".op_1"},   bus.op_1_o, op1);
    chk({tag, ".op_2"},   bus.op_2_o, op2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.instr_valid_in = 1'b0;
    bus.instr_in       = 32'h0;
    bus.rs1_data_in    = 32'h0;
    bus.rs2_data_in    = 32'h0;
    bus.wb_ready_in    = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wb_valid", {31'b0, bus.wb_valid_o}, 32'd0);
    chk("rst_op_1",     bus.op_1_o, 32'd0);
    chk("rst_op_2",     bus.op_2_o, 32'd0);
    chk("rst_opcode",   {28'b0, bus.opcode_o}, 32'd0);
    chk("rst_wb_data",  bus.wb_data_o, 32'd0);
    chk("rst_wb_ctl",   {25'b0, bus.wb_rd_o, bus.wb_we_o, bus.wb_illegal_o}, 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_ready", {31'b0, bus.instr_ready_o}, 32'd1);
    @(negedge clk);

    // add x3,x1,x2 with latency check
    send_chk("add", 32'h002081B3, 32'd5, 32'd7, 5'd3, 32'd12, 1'b1, 1'b0, 4'b0000, 32'd5, 32'd7);
    chk("lat_n1_wb_valid", {31'b0, bus.wb_valid_o}, 32'd0);
    @(negedge clk);
    chk("lat_n2_wb_valid", {31'b0, bus.wb_valid_o}, 32'd1);

    send_chk("sub",   32'h402081B3, 32'd5, 32'd7, 5'd3, 32'hFFFFFFFE, 1'b1, 1'b0, 4'b1000, 32'd5, 32'd7);
    send_chk("srai",  32'h4040D193, 32'h80000000, 32'h0, 5'd3, 32'hF8000000, 1'b1, 1'b0, 4'b1101, 32'h80000000, 32'd4);
    send_chk("addi",  32'hFFF00093, 32'h0, 32'h0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b0000, 32'h0, 32'hFFFFFFFF);
    send_chk("sltiu", 32'h4000B213, 32'd5, 32'h0, 5'd4, 32'd1, 1'b1, 1'b0, 4'b0011, 32'd5, 32'h400);
    send_chk("lui",   32'h123452B7, 32'hDEAD, 32'hBEEF, 5'd5, 32'h12345000, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h12345000);
    send_chk("illegal_zero", 32'h00000000, 32'd5, 32'd7, 5'd0, 32'd0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0);
    send_chk("add_x0", 32'h00208033, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0, 4'b0000, 32'd5, 32'd7);
    send_chk("xor_alt_illegal", 32'h4020C1B3, 32'd5, 32'd7, 5'd3, 32'd0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0);
`ifdef ALU_DEC_SHAMT_MASK_EN
    send_chk("sll_mask", 32'h00209533, 32'd1, 32'h21, 5'd10, 32'd2, 1'b1, 1'b0, 4'b0001, 32'd1, 32'd1);
`else
    send_chk("sll_full", 32'h00209533, 32'd1, 32'h21, 5'd10, 32'd0, 1'b1, 1'b0, 4'b0001, 32'd1, 32'h21);
`endif
    repeat (3) @(negedge clk);
    chk("drain_1", 32'(sb_q.size()), 32'd0);

    // Backpressure: 4 instructions, consumer stalled for 3 cycles
    bus.wb_ready_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(32'h00208033 | (32'(6 + i) << 7), 32'(i + 1), 32'h100,
            5'(6 + i), 32'(i + 1 + 32'h100), 1'b1, 1'b0);
      wait_accept();
    end
    drive(32'h00208033 | (32'd8 << 7), 32'd3, 32'h100, 5'd8, 32'h103, 1'b1, 1'b0);
    #1 chk("bp_ready_c1", {31'b0, bus.instr_ready_o}, 32'd0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      #1 chk("bp_ready_low", {31'b0, bus.instr_ready_o}, 32'd0);
    end
    @(negedge clk);
    bus.wb_ready_in = 1'b1;
    wait_accept();
    drive(32'h00208033 | (32'd9 << 7), 32'd4, 32'h100, 5'd9, 32'h104, 1'b1, 1'b0);
    wait_accept();
    repeat (4) @(negedge clk);
    chk("drain_2", 32'(sb_q.size()), 32'd0);

    // Reset with both stages full
    bus.wb_ready_in = 1'b0;
    drive(32'h00208333, 32'd1, 32'd2, 5'd6, 32'd3, 1'b1, 1'b0);
    wait_accept();
    drive(32'h002083B3, 32'd1, 32'd2, 5'd7, 32'd3, 1'b1, 1'b0);
    wait_accept();
    chk("full_wb_valid", {31'b0, bus.wb_valid_o}, 32'd1);
    #3 rst_n = 1'b0;
    #1 chk("async_rst_wb_valid", {31'b0, bus.wb_valid_o}, 32'd0);
    chk("async_rst_op_1", bus.op_1_o, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.wb_ready_in = 1'b1;
    @(negedge clk);

    // Recovery after reset
    send_chk("post_rst_add", 32'h002081B3, 32'd5, 32'd7, 5'd3, 32'd12, 1'b1, 1'b0, 4'b0000, 32'd5, 32'd7);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
